// File: rtl/rx66_pkg.sv
// Shared types and constants for the 66b receive path.
//   lock_state_t : block-lock FSM state encoding (matches state_o)
//   c_*          : sync header codes and highest legal header offset
//   hdr_valid()  : 1 when a 2-bit sync header is a legal data/control header
package rx66_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHunt   = 2'd1,
    StVerify = 2'd2,
    StLocked = 2'd3
  } lock_state_t;

  localparam logic [1:0] c_DATA_HEADER = 2'b01;
  localparam logic [1:0] c_CMD_HEADER  = 2'b10;
  localparam logic [6:0] c_MAX_OFFSET  = 7'd65;

  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == c_DATA_HEADER) || (hdr == c_CMD_HEADER);
  endfunction

endpackage

// File: rtl/hdr_err_window.sv
// Windowed bad-header counter used while block lock is held.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   clr_i           : holds both counters at zero
//   hdr_dv_i        : one header sampled this cycle
//   bad_i           : the sampled header is invalid
//   bad_max_hit_o   : this sample is the BAD_MAX-th bad header of the window
module hdr_err_window
  import rx66_pkg::*;
#(
  parameter int unsigned WIN_LEN = 64,
  parameter int unsigned BAD_MAX = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic hdr_dv_i,
  input  logic bad_i,
  output logic bad_max_hit_o
);

  localparam logic [7:0] WinLen = 8'(WIN_LEN);
  localparam logic [7:0] BadMax = 8'(BAD_MAX);

  logic [7:0] win_cnt_q, win_cnt_d;
  logic [7:0] bad_cnt_q, bad_cnt_d;
  logic [7:0] win_inc, bad_inc;

  always_comb begin
    win_inc       = win_cnt_q + 8'd1;
    bad_inc       = bad_cnt_q + {7'd0, bad_i};
    bad_max_hit_o = hdr_dv_i && bad_i && (bad_inc == BadMax);
    win_cnt_d     = win_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    if (clr_i) begin
      win_cnt_d = 8'd0;
      bad_cnt_d = 8'd0;
    end else if (hdr_dv_i) begin
      // A threshold hit takes priority over the window end; either way restart.
      if (bad_max_hit_o || (win_inc == WinLen)) begin
        win_cnt_d = 8'd0;
        bad_cnt_d = 8'd0;
      end else begin
        win_cnt_d = win_inc;
        bad_cnt_d = bad_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_cnt_q <= 8'd0;
      bad_cnt_q <= 8'd0;
    end else begin
      win_cnt_q <= win_cnt_d;
      bad_cnt_q <= bad_cnt_d;
    end
  end

endmodule

// File: rtl/block_lock_ctrl.sv
// Block-lock controller for the 66b receive path. Commits a stable seeker
// candidate offset, verifies sync headers at it, then monitors lock.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   enable_i         : 0 forces IDLE
//   cand_offset_i    : seeker candidate (legal 0..65), cand_dv_i strobe
//   hdr_i, hdr_dv_i  : sync header at offset_o and its strobe
//   offset_o         : committed offset, offset_ld_o pulses on commit
//   seeker_rst_o     : restart pulse to the seeker
//   lock_o, state_o  : lock status and FSM state
//   lock_loss_cnt_o  : saturating count of lock losses
module block_lock_ctrl
  import rx66_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 8,
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned WIN_LEN    = 64,
  parameter int unsigned BAD_MAX    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [6:0] cand_offset_i,
  input  logic       cand_dv_i,
  input  logic [1:0] hdr_i,
  input  logic       hdr_dv_i,
  output logic [6:0] offset_o,
  output logic       offset_ld_o,
  output logic       seeker_rst_o,
  output logic       lock_o,
  output logic [1:0] state_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CNT);
  localparam logic [7:0] LockCnt   = 8'(LOCK_CNT);

  lock_state_t state_q;
  logic [6:0]  offset_q, cand_q;
  logic        offset_ld_q, seeker_rst_q, lock_q;
  logic [7:0]  loss_cnt_q, stab_cnt_q, good_cnt_q;

  logic [7:0]  stab_nxt, good_inc;
  logic        hdr_ok, win_clr, bad_max_hit;

  assign hdr_ok   = hdr_valid(hdr_i);
  assign good_inc = good_cnt_q + 8'd1;

  // Out-of-range candidates zero stability; a repeat of the last sample extends it.
  always_comb begin
    if (cand_offset_i > c_MAX_OFFSET) begin
      stab_nxt = 8'd0;
    end else if (cand_offset_i == cand_q) begin
      stab_nxt = stab_cnt_q + 8'd1;
    end else begin
      stab_nxt = 8'd1;
    end
  end

  // Window counters only run while locked; any other state keeps them clear.
  assign win_clr = (state_q != StLocked) || !enable_i;

  hdr_err_window #(
    .WIN_LEN (WIN_LEN),
    .BAD_MAX (BAD_MAX)
  ) u_hdr_err_window (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clr_i         (win_clr),
    .hdr_dv_i      (hdr_dv_i),
    .bad_i         (!hdr_ok),
    .bad_max_hit_o (bad_max_hit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      offset_q     <= 7'd0;
      cand_q       <= 7'd0;
      offset_ld_q  <= 1'b0;
      seeker_rst_q <= 1'b0;
      lock_q       <= 1'b0;
      loss_cnt_q   <= 8'd0;
      stab_cnt_q   <= 8'd0;
      good_cnt_q   <= 8'd0;
    end else begin
      offset_ld_q  <= 1'b0;
      seeker_rst_q <= 1'b0;
      if (!enable_i) begin
        state_q    <= StIdle;
        lock_q     <= 1'b0;
        stab_cnt_q <= 8'd0;
        good_cnt_q <= 8'd0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q      <= StHunt;
            seeker_rst_q <= 1'b1;
            stab_cnt_q   <= 8'd0;
            good_cnt_q   <= 8'd0;
          end
          StHunt: begin
            if (cand_dv_i) begin
              cand_q     <= cand_offset_i;
              stab_cnt_q <= stab_nxt;
              if (stab_nxt == StableCnt) begin
                offset_q    <= cand_offset_i;
                offset_ld_q <= 1'b1;
                state_q     <= StVerify;
                stab_cnt_q  <= 8'd0;
                good_cnt_q  <= 8'd0;
              end
            end
          end
          StVerify: begin
            if (hdr_dv_i) begin
              if (hdr_ok) begin
                good_cnt_q <= good_inc;
                if (good_inc == LockCnt) begin
                  state_q    <= StLocked;
                  lock_q     <= 1'b1;
                  good_cnt_q <= 8'd0;
                end
              end else begin
                state_q      <= StHunt;
                seeker_rst_q <= 1'b1;
                stab_cnt_q   <= 8'd0;
                good_cnt_q   <= 8'd0;
              end
            end
          end
          StLocked: begin
            if (bad_max_hit) begin
              state_q      <= StHunt;
              lock_q       <= 1'b0;
              seeker_rst_q <= 1'b1;
              stab_cnt_q   <= 8'd0;
              if (loss_cnt_q != 8'hFF) loss_cnt_q <= loss_cnt_q + 8'd1;
            end
          end
        endcase
      end
    end
  end

  assign offset_o        = offset_q;
  assign offset_ld_o     = offset_ld_q;
  assign seeker_rst_o    = seeker_rst_q;
  assign lock_o          = lock_q;
  assign state_o         = state_q;
  assign lock_loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_block_lock_ctrl.sv
module tb_block_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       enable_i = 1'b0;
  logic [6:0] cand_offset_i = 7'd0;
  logic       cand_dv_i = 1'b0;
  logic [1:0] hdr_i = 2'b00;
  logic       hdr_dv_i = 1'b0;
  logic [6:0] offset_o;
  logic       offset_ld_o, seeker_rst_o, lock_o;
  logic [1:0] state_o;
  logic [7:0] lock_loss_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  block_lock_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .cand_offset_i   (cand_offset_i),
    .cand_dv_i       (cand_dv_i),
    .hdr_i           (hdr_i),
    .hdr_dv_i        (hdr_dv_i),
    .offset_o        (offset_o),
    .offset_ld_o     (offset_ld_o),
    .seeker_rst_o    (seeker_rst_o),
    .lock_o          (lock_o),
    .state_o         (state_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  // Inputs change 1 ns after an edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cand(input logic [6:0] off);
    cand_offset_i = off;
    cand_dv_i     = 1'b1;
    tick();
    cand_dv_i     = 1'b0;
  endtask

  task automatic send_hdr(input logic [1:0] h);
    hdr_i    = h;
    hdr_dv_i = 1'b1;
    tick();
    hdr_dv_i = 1'b0;
  endtask

  // Stimulus only: commit 'off' from HUNT and collect LOCK_CNT good headers.
  task automatic drive_to_lock(input logic [6:0] off);
    for (int i = 0; i < 8; i++) send_cand(off);
    for (int i = 0; i < 32; i++) send_hdr(2'b10);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks++;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_checks++;
    if (offset_o !== 7'd0) begin n_fail++; $display("FAIL reset_offset: got %0d want 0", offset_o); end
    n_checks++;
    if ({lock_o, offset_ld_o, seeker_rst_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {lock_o, offset_ld_o, seeker_rst_o});
    end
    n_checks++;
    if (lock_loss_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_loss: got %0d want 0", lock_loss_cnt_o); end
    tick();
    n_checks++;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL idle_hold: got %0d want 0", state_o); end
  endtask

  task automatic test_clean_lock();
    enable_i = 1'b1;
    tick();
    n_checks++;
    if (seeker_rst_o !== 1'b1 || state_o !== 2'd1) begin
      n_fail++; $display("FAIL enable_pulse: got rst=%b st=%0d want rst=1 st=1", seeker_rst_o, state_o);
    end
    tick();
    n_checks++;
    if (seeker_rst_o !== 1'b0) begin n_fail++; $display("FAIL enable_pulse_len: got %b want 0", seeker_rst_o); end
    for (int i = 0; i < 7; i++) send_cand(7'd23);
    n_checks++;
    if (state_o !== 2'd1 || offset_ld_o !== 1'b0) begin
      n_fail++; $display("FAIL early_commit: got st=%0d ld=%b want st=1 ld=0", state_o, offset_ld_o);
    end
    send_cand(7'd23);
    n_checks++;
    if (offset_ld_o !== 1'b1 || offset_o !== 7'd23 || state_o !== 2'd2) begin
      n_fail++;
      $display("FAIL commit23: got ld=%b off=%0d st=%0d want ld=1 off=23 st=2", offset_ld_o, offset_o, state_o);
    end
    tick();
    n_checks++;
    if (offset_ld_o !== 1'b0) begin n_fail++; $display("FAIL ld_pulse_len: got %b want 0", offset_ld_o); end
    for (int i = 0; i < 31; i++) send_hdr(i[0] ? 2'b10 : 2'b01);
    n_checks++;
    if (lock_o !== 1'b0 || state_o !== 2'd2) begin
      n_fail++; $display("FAIL early_lock: got lock=%b st=%0d want lock=0 st=2", lock_o, state_o);
    end
    send_hdr(2'b01);
    n_checks++;
    if (lock_o !== 1'b1 || state_o !== 2'd3) begin
      n_fail++; $display("FAIL lock32: got lock=%b st=%0d want lock=1 st=3", lock_o, state_o);
    end
  endtask

  task automatic test_loss_of_lock();
    for (int i = 0; i < 15; i++) send_hdr(i[0] ? 2'b00 : 2'b11);
    n_checks++;
    if (lock_o !== 1'b1) begin n_fail++; $display("FAIL bad15_lock: got %b want 1", lock_o); end
    send_hdr(2'b11);
    n_checks++;
    if (lock_o !== 1'b0 || state_o !== 2'd1 || seeker_rst_o !== 1'b1) begin
      n_fail++;
      $display("FAIL loss16: got lock=%b st=%0d rst=%b want 0/1/1", lock_o, state_o, seeker_rst_o);
    end
    n_checks++;
    if (lock_loss_cnt_o !== 8'd1) begin n_fail++; $display("FAIL loss_cnt1: got %0d want 1", lock_loss_cnt_o); end
    tick();
    n_checks++;
    if (seeker_rst_o !== 1'b0) begin n_fail++; $display("FAIL loss_pulse_len: got %b want 0", seeker_rst_o); end
  endtask

  task automatic test_unstable();
    for (int i = 0; i < 5; i++) send_cand(7'd23);
    for (int i = 0; i < 7; i++) send_cand(7'd24);
    n_checks++;
    if (state_o !== 2'd1 || offset_ld_o !== 1'b0) begin
      n_fail++; $display("FAIL unstable_early: got st=%0d ld=%b want st=1 ld=0", state_o, offset_ld_o);
    end
    send_cand(7'd24);
    n_checks++;
    if (offset_ld_o !== 1'b1 || offset_o !== 7'd24 || state_o !== 2'd2) begin
      n_fail++;
      $display("FAIL commit24: got ld=%b off=%0d st=%0d want ld=1 off=24 st=2", offset_ld_o, offset_o, state_o);
    end
  endtask

  task automatic test_verify_fail();
    for (int i = 0; i < 10; i++) send_hdr(2'b01);
    send_hdr(2'b11);
    n_checks++;
    if (state_o !== 2'd1 || seeker_rst_o !== 1'b1 || lock_o !== 1'b0) begin
      n_fail++;
      $display("FAIL verify_fail: got st=%0d rst=%b lock=%b want 1/1/0", state_o, seeker_rst_o, lock_o);
    end
    n_checks++;
    if (offset_o !== 7'd24) begin n_fail++; $display("FAIL verify_fail_off: got %0d want 24", offset_o); end
  endtask

  task automatic test_invalid_cand();
    // Headers in HUNT must not matter.
    hdr_i = 2'b11; hdr_dv_i = 1'b1;
    for (int i = 0; i < 5; i++) send_cand(7'd23);
    send_cand(7'd70);
    for (int i = 0; i < 7; i++) send_cand(7'd23);
    hdr_dv_i = 1'b0;
    n_checks++;
    if (state_o !== 2'd1 || offset_ld_o !== 1'b0 || offset_o !== 7'd24) begin
      n_fail++;
      $display("FAIL cand70: got st=%0d ld=%b off=%0d want 1/0/24", state_o, offset_ld_o, offset_o);
    end
    send_cand(7'd23);
    n_checks++;
    if (offset_ld_o !== 1'b1 || offset_o !== 7'd23) begin
      n_fail++; $display("FAIL cand70_commit: got ld=%b off=%0d want 1/23", offset_ld_o, offset_o);
    end
  endtask

  task automatic test_window_hold();
    for (int i = 0; i < 32; i++) send_hdr(2'b01);
    n_checks++;
    if (lock_o !== 1'b1) begin n_fail++; $display("FAIL relock: got %b want 1", lock_o); end
    // 15 bad at the tail of each window: back-to-back across boundaries.
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 64; i++) send_hdr((i >= 49) ? 2'b00 : 2'b10);
      n_checks++;
      if (lock_o !== 1'b1 || state_o !== 2'd3) begin
        n_fail++; $display("FAIL window%0d_hold: got lock=%b st=%0d want 1/3", w, lock_o, state_o);
      end
    end
    // 16th bad landing on the window's last sample still drops lock.
    for (int i = 0; i < 63; i++) send_hdr((i >= 48) ? 2'b11 : 2'b01);
    n_checks++;
    if (lock_o !== 1'b1) begin n_fail++; $display("FAIL win_end_pre: got %b want 1", lock_o); end
    send_hdr(2'b11);
    n_checks++;
    if (lock_o !== 1'b0 || lock_loss_cnt_o !== 8'd2 || seeker_rst_o !== 1'b1) begin
      n_fail++;
      $display("FAIL win_end_loss: got lock=%b cnt=%0d rst=%b want 0/2/1", lock_o, lock_loss_cnt_o, seeker_rst_o);
    end
  endtask

  task automatic test_disable();
    drive_to_lock(7'd40);
    n_checks++;
    if (lock_o !== 1'b1 || offset_o !== 7'd40) begin
      n_fail++; $display("FAIL dis_prelock: got lock=%b off=%0d want 1/40", lock_o, offset_o);
    end
    enable_i = 1'b0;
    tick();
    n_checks++;
    if (state_o !== 2'd0 || lock_o !== 1'b0 || lock_loss_cnt_o !== 8'd2) begin
      n_fail++;
      $display("FAIL disable: got st=%0d lock=%b cnt=%0d want 0/0/2", state_o, lock_o, lock_loss_cnt_o);
    end
    send_cand(7'd40);
    n_checks++;
    if (state_o !== 2'd0 || seeker_rst_o !== 1'b0) begin
      n_fail++; $display("FAIL disable_hold: got st=%0d rst=%b want 0/0", state_o, seeker_rst_o);
    end
    enable_i = 1'b1;
    tick();
    n_checks++;
    if (seeker_rst_o !== 1'b1 || state_o !== 2'd1) begin
      n_fail++; $display("FAIL reenable: got rst=%b st=%0d want 1/1", seeker_rst_o, state_o);
    end
  endtask

  task automatic test_reset_mid_verify();
    for (int i = 0; i < 8; i++) send_cand(7'd12);
    for (int i = 0; i < 5; i++) send_hdr(2'b01);
    n_checks++;
    if (state_o !== 2'd2 || offset_o !== 7'd12) begin
      n_fail++; $display("FAIL pre_rst: got st=%0d off=%0d want 2/12", state_o, offset_o);
    end
    rst_i = 1'b1; hdr_i = 2'b11; hdr_dv_i = 1'b1;
    tick();
    n_checks++;
    if (state_o !== 2'd0 || offset_o !== 7'd0 || lock_loss_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got st=%0d off=%0d cnt=%0d want 0/0/0", state_o, offset_o, lock_loss_cnt_o);
    end
    n_checks++;
    if ({lock_o, offset_ld_o, seeker_rst_o} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_flags: got %b want 000", {lock_o, offset_ld_o, seeker_rst_o});
    end
    tick();
    hdr_dv_i = 1'b0;
    n_checks++;
    if (seeker_rst_o !== 1'b0 || state_o !== 2'd0) begin
      n_fail++; $display("FAIL rst_hold: got rst=%b st=%0d want 0/0", seeker_rst_o, state_o);
    end
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_loss_of_lock();
    test_unstable();
    test_verify_fail();
    test_invalid_cand();
    test_window_hold();
    test_disable();
    test_reset_mid_verify();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
